// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-7-segment decoder for the multiplexed display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam logic [3:0] BIN_RESET = 4'd8;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] pattern;
      case (hex)
         4'h0: pattern = 7'b1000000;
         4'h1: pattern = 7'b1111001;
         4'h2: pattern = 7'b0100100;
         4'h3: pattern = 7'b0110000;
         4'h4: pattern = 7'b0011001;
         4'h5: pattern = 7'b0010010;
         4'h6: pattern = 7'b0000010;
         4'h7: pattern = 7'b1111000;
         4'h8: pattern = 7'b0000000;
         4'h9: pattern = 7'b0010000;
         4'hA: pattern = 7'b0001000;
         4'hB: pattern = 7'b0000011;
         4'hC: pattern = 7'b1000110;
         4'hD: pattern = 7'b0100001;
         4'hE: pattern = 7'b0000110;
         default: pattern = 7'b0001110;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Builds the per-digit blank mask: forced blanks plus leading-zero suppression.
// Bit order matches the digit bus, so bit NUM_DIGITS-1 is the leftmost digit.
module seg_lz_mask
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic                    lz_sup,
   input  logic [NUM_DIGITS-1:0]   blank,
   output logic [NUM_DIGITS-1:0]   mask
);

   logic zero_run;

   // Walk from the most significant digit down; the run stays true only while every digit so far is zero.
   always_comb begin
      mask     = blank;
      zero_run = lz_sup;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (digits[4*i +: 4] == 4'h0);
         if (i != 0 && zero_run) begin
            mask[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_ctl.sv
// Multiplexed 7-segment scan controller: prescaler, slot counter, frame-synchronous
// shadow registers and fully registered anode/segment outputs.
module seg_scan_ctl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DIV_BITS    = 16,
   parameter int BRIGHT_BITS = 3
) (
   input  logic                    clk,
   input  logic                    rst_p,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_sup,
   input  logic [BRIGHT_BITS-1:0]  brightness,
   output logic [NUM_DIGITS-1:0]   dis,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [3:0]              bin_out,
   output logic                    frame_tick
);

   localparam int SLOT_BITS = $clog2(NUM_DIGITS);

   logic [DIV_BITS-1:0]     prescaler;
   logic [SLOT_BITS-1:0]    slot;
   logic [SLOT_BITS-1:0]    digit_idx;
   logic                    frame_start;

   logic [4*NUM_DIGITS-1:0] digits_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;
   logic                    lz_sh;

   logic [4*NUM_DIGITS-1:0] cur_digits;
   logic [NUM_DIGITS-1:0]   cur_dp;
   logic [NUM_DIGITS-1:0]   cur_blank;
   logic                    cur_lz;
   logic [NUM_DIGITS-1:0]   blank_mask;

   logic [3:0]              nibble;
   logic                    lit;
   logic                    pwm_on;
   logic [NUM_DIGITS-1:0]   dis_d;
   logic [6:0]              seg_d;
   logic                    dp_d;

   assign frame_start = (prescaler == '0) && (slot == '0);
   assign digit_idx   = SLOT_BITS'(NUM_DIGITS - 1) - slot;

   // On the frame-start cycle the fresh inputs bypass the shadows so slot 0 already shows the new frame.
   assign cur_digits = frame_start ? digits_in : digits_sh;
   assign cur_dp     = frame_start ? dp_in     : dp_sh;
   assign cur_blank  = frame_start ? blank_in  : blank_sh;
   assign cur_lz     = frame_start ? lz_sup    : lz_sh;

   seg_lz_mask #(
      .NUM_DIGITS(NUM_DIGITS)
   ) u_lz_mask (
      .digits(cur_digits),
      .lz_sup(cur_lz),
      .blank (cur_blank),
      .mask  (blank_mask)
   );

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         prescaler <= '0;
         slot      <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
         if (prescaler == '1) begin
            slot <= (slot == SLOT_BITS'(NUM_DIGITS - 1)) ? '0 : slot + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         digits_sh <= '0;
         dp_sh     <= '0;
         blank_sh  <= '0;
         lz_sh     <= 1'b0;
      end else if (frame_start) begin
         digits_sh <= digits_in;
         dp_sh     <= dp_in;
         blank_sh  <= blank_in;
         lz_sh     <= lz_sup;
      end
   end

   // Brightness acts on the anode only; segments keep their pattern through the PWM off-time.
   always_comb begin
      nibble = cur_digits[4*digit_idx +: 4];
      lit    = ~blank_mask[digit_idx];
      pwm_on = (prescaler[DIV_BITS-1 -: BRIGHT_BITS] <= brightness);
      dis_d  = '1;
      seg_d  = SEG_OFF;
      dp_d   = 1'b1;
      if (lit) begin
         seg_d = hex_to_seg(nibble);
         dp_d  = ~cur_dp[digit_idx];
         if (pwm_on) begin
            dis_d[digit_idx] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         dis        <= '1;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         bin_out    <= BIN_RESET;
         frame_tick <= 1'b0;
      end else begin
         dis        <= dis_d;
         seg        <= seg_d;
         dp         <= dp_d;
         bin_out    <= nibble;
         frame_tick <= frame_start;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctl.sv
// Scoreboard bench for seg_scan_ctl: a 4-digit and a 6-digit instance run side by side
// against a cycle-count based reference model.
module tb_seg_scan_ctl;

   localparam int DIV_BITS    = 4;
   localparam int BRIGHT_BITS = 2;
   localparam int SLOT_LEN    = 16;

   typedef struct {
      int         n;
      logic [7:0] dis;
      logic [6:0] seg;
      logic       dp;
      logic [3:0] bin;
      logic       ft;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_p = 1'b1;
   logic [31:0] digits_v = '0;
   logic [7:0]  dp_v = '0;
   logic [7:0]  blank_v = '0;
   logic        lz_v = 1'b0;
   logic [1:0]  bright_v = 2'd3;

   logic [3:0]  dis4;
   logic [6:0]  seg4;
   logic        dp4;
   logic [3:0]  bin4;
   logic        ft4;
   logic [5:0]  dis6;
   logic [6:0]  seg6;
   logic        dp6;
   logic [3:0]  bin6;
   logic        ft6;

   int checks = 0;
   int errors = 0;
   int t = 0;
   exp_t q[$];

   logic [31:0] sh_d  [2];
   logic [7:0]  sh_dp [2];
   logic [7:0]  sh_bl [2];
   logic        sh_lz [2];

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg_scan_ctl #(.NUM_DIGITS(4), .DIV_BITS(DIV_BITS), .BRIGHT_BITS(BRIGHT_BITS)) u_dut4 (
      .clk(clk), .rst_p(rst_p), .digits_in(digits_v[15:0]), .dp_in(dp_v[3:0]),
      .blank_in(blank_v[3:0]), .lz_sup(lz_v), .brightness(bright_v),
      .dis(dis4), .seg(seg4), .dp(dp4), .bin_out(bin4), .frame_tick(ft4)
   );

   seg_scan_ctl #(.NUM_DIGITS(6), .DIV_BITS(DIV_BITS), .BRIGHT_BITS(BRIGHT_BITS)) u_dut6 (
      .clk(clk), .rst_p(rst_p), .digits_in(digits_v[23:0]), .dp_in(dp_v[5:0]),
      .blank_in(blank_v[5:0]), .lz_sup(lz_v), .brightness(bright_v),
      .dis(dis6), .seg(seg6), .dp(dp6), .bin_out(bin6), .frame_tick(ft6)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s t=%0d got %h expected %h", tag, t, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] d, input logic [7:0] dpv, input logic [7:0] blv,
                                input logic lz, input logic [1:0] br);
      digits_v = d;
      dp_v     = dpv;
      blank_v  = blv;
      lz_v     = lz;
      bright_v = br;
   endtask

   // Expected pins for scan time t, derived from elapsed cycles rather than counter state.
   function automatic exp_t model(input int c, input int n, input int tt);
      exp_t        e;
      int          slot_i;
      int          pre;
      int          idx;
      logic [31:0] dmask;
      logic [31:0] upper;
      logic        blanked;
      slot_i  = (tt / SLOT_LEN) % n;
      pre     = tt % SLOT_LEN;
      idx     = n - 1 - slot_i;
      dmask   = (32'd1 << (4 * n)) - 32'd1;
      upper   = (sh_d[c] & dmask) >> (4 * idx);
      e.n     = n;
      e.bin   = upper[3:0];
      blanked = sh_bl[c][idx] || (sh_lz[c] && idx != 0 && upper == 32'd0);
      e.dis   = 8'((32'd1 << n) - 32'd1);
      if (!blanked && (pre / 4) <= int'(bright_v)) e.dis[idx] = 1'b0;
      e.seg   = blanked ? 7'h7F : seg_tbl[e.bin];
      e.dp    = blanked ? 1'b1 : ~sh_dp[c][idx];
      e.ft    = (tt % (SLOT_LEN * n)) == 0;
      return e;
   endfunction

   task automatic tick();
      exp_t e;
      int   ns [2] = '{4, 6};
      for (int c = 0; c < 2; c++) begin
         if (t % (SLOT_LEN * ns[c]) == 0) begin
            sh_d[c]  = digits_v;
            sh_dp[c] = dp_v;
            sh_bl[c] = blank_v;
            sh_lz[c] = lz_v;
         end
         q.push_back(model(c, ns[c], t));
      end
      @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      checkOutput("dis4", {28'd0, dis4}, {24'd0, e.dis});
      checkOutput("seg4", {25'd0, seg4}, {25'd0, e.seg});
      checkOutput("dp4",  {31'd0, dp4},  {31'd0, e.dp});
      checkOutput("bin4", {28'd0, bin4}, {28'd0, e.bin});
      checkOutput("ft4",  {31'd0, ft4},  {31'd0, e.ft});
      e = q.pop_front();
      checkOutput("dis6", {26'd0, dis6}, {24'd0, e.dis});
      checkOutput("seg6", {25'd0, seg6}, {25'd0, e.seg});
      checkOutput("dp6",  {31'd0, dp6},  {31'd0, e.dp});
      checkOutput("bin6", {28'd0, bin6}, {28'd0, e.bin});
      checkOutput("ft6",  {31'd0, ft6},  {31'd0, e.ft});
      checkOutput("one_anode6", 32'($countones(~dis6) <= 1), 32'd1);
      t++;
   endtask

   task automatic runCycles(input int count);
      for (int i = 0; i < count; i++) tick();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_dis4"}, {28'd0, dis4}, 32'h0000000F);
      checkOutput({tag, "_seg4"}, {25'd0, seg4}, 32'h0000007F);
      checkOutput({tag, "_dp4"},  {31'd0, dp4},  32'd1);
      checkOutput({tag, "_bin4"}, {28'd0, bin4}, 32'd8);
      checkOutput({tag, "_ft4"},  {31'd0, ft4},  32'd0);
      checkOutput({tag, "_dis6"}, {26'd0, dis6}, 32'h0000003F);
      checkOutput({tag, "_bin6"}, {28'd0, bin6}, 32'd8);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_p = 1'b0;
      t     = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at t=%0d", t);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      applyStimulus(32'h0056_1234, 8'b0000_0010, 8'h00, 1'b0, 2'd3);
      #12;
      checkResetValues("reset");
      releaseReset();
      runCycles(100);

      // Frame 1 of the 4-digit scan is in slot 2 here, so A..D must wait for the next frame.
      applyStimulus(32'h00EF_ABCD, 8'b0000_0100, 8'h00, 1'b0, 2'd3);
      runCycles(100);

      @(posedge clk);
      #3 rst_p = 1'b1;
      #1 checkResetValues("midreset");
      @(negedge clk);
      applyStimulus(32'h0000_0050, 8'h00, 8'h00, 1'b1, 2'd3);
      releaseReset();
      runCycles(200);

      applyStimulus(32'h0000_0000, 8'h00, 8'h00, 1'b1, 2'd3);
      runCycles(200);

      applyStimulus(32'h0000_0000, 8'h00, 8'b0000_0001, 1'b1, 2'd3);
      runCycles(200);

      applyStimulus(32'h0098_7654, 8'b0010_1001, 8'h00, 1'b0, 2'd0);
      runCycles(100);
      bright_v = 2'd2;
      runCycles(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
